stf_seq_ctrl: RTL and testbench
===============================

Name: stf_seq_ctrl

Overview:
- Sequencer that drives the combinational short-training-field generator to produce one complete 802.11 STF burst.
- Latches the 24-bit subcarrier coefficient word on start and steps the 4-bit ROM address 0..15, NUM_REPS times.
- Registers each generated 32-bit I/Q sample into a valid/ready output stage and flags the last sample.
- Sits between the TX control FSM (start/abort/done) and the sample mux feeding the IFFT-bypass/DAC path.

Parameters:
- NUM_REPS, 10, number of 16-sample short symbols per burst; legal range 1..15.
- SAMPLE_W, 32, width of an I/Q sample as {I[15:0], Q[15:0]}.

Ports:
- clk  in  1  single clock for the whole block.
- rstn  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- abort  in  1  synchronous abort; wins over every other event.
- coeffs_in  in  24  coefficient word captured on accepted start.
- stf_addr  out  4  address to generator.
- stf_coeffs  out  24  latched coefficients to generator.
- stf_symbol  in  32  generator output for the current stf_addr/stf_coeffs (combinational).
- out_data  out  32  registered sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the sample when out_valid && out_ready.
- out_last  out  1  qualifies the final sample of the burst.
- busy  out  1  high from the cycle after an accepted start until the burst ends.
- done  out  1  one-cycle pulse when the last sample is accepted.

Behaviour:
- Reset values: stf_addr=0, stf_coeffs=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, state=IDLE, sample counter=0.
- States:
  - IDLE: start=1 -> latch coeffs_in into stf_coeffs, counter=0, stf_addr=0, go RUN, busy=1 next cycle.
  - RUN: load output register whenever (!out_valid || out_ready).
    - On each load: out_data<=stf_symbol, out_valid<=1, out_last<=(counter==NUM_REPS*16-1).
    - After each load: counter++, stf_addr<=counter[3:0]+1, wrapping 15->0.
    - After loading the sample with counter==NUM_REPS*16-1: go DRAIN, no further loads.
  - DRAIN: hold out_data/out_last until accepted.
    - On out_valid&&out_ready: out_valid<=0, out_last<=0, done=1 for one cycle, busy<=0, go IDLE.
- Latency: first out_valid appears 2 cycles after the start cycle; 1 sample/cycle sustained while out_ready=1.
  - Total burst with out_ready held high: NUM_REPS*16 valid cycles.
- Backpressure: while out_valid && !out_ready, out_data, out_last and stf_addr hold, and the counter does not advance.
- start in RUN/DRAIN is ignored; coeffs_in changes after capture have no effect.
- abort in any state: next cycle out_valid=0, out_last=0, busy=0, counter=0, stf_addr=0, state=IDLE, and done is not pulsed. stf_coeffs is retained.
- abort and start in the same IDLE cycle: abort wins, no burst starts.
- start in the same cycle as the done pulse is ignored; state is IDLE only from the following cycle.
- Counter width is 8 bits; NUM_REPS*16 ≤ 240, so no overflow.

Optional Feature:
- Macro: STF_WINDOW_EN.
- Defined: the first sample (counter==0) is loaded with I and Q each arithmetic-shifted right by 1, implementing the 802.11 time-domain window; all other samples pass unchanged.
  - Shift is applied per 16-bit half with sign extension, so -1 stays -1.
- Not defined: every sample passes unchanged; no added logic.

Test Plan:
- Reset then start with coeffs_in=24'hAAAAAA and out_ready=1 -> out_valid from cycle start+2 for exactly 160 cycles.
  - stf_addr sequence 0..15 repeated 10 times.
  - out_last only on the 160th sample; done pulses once on the same cycle that sample is accepted; busy low afterwards.
- Same run with out_ready toggling 1,0,0,1 pattern -> out_data stable while stalled, no samples skipped or duplicated.
  - Captured stream equals the free-running stream, 160 samples.
- abort asserted after 37 accepted samples -> next cycle out_valid=0, busy=0, stf_addr=0, no done pulse.
  - A new start then yields a full 160-sample burst.
- start re-pulsed during RUN with coeffs_in=24'h555555 -> ignored; stf_coeffs stays 24'hAAAAAA for the whole burst.
- STF_WINDOW_EN defined, stf_symbol first value 32'h8000_0002 -> first out_data=32'hC000_0001, second sample unshifted.
  - Without the macro, first out_data=32'h8000_0002.
- NUM_REPS=1, out_ready=1 -> 16 samples, out_last on addr 15, done once; back-to-back start the cycle after done -> second burst begins normally.

Source files
------------

// File: rtl/stf_seq_ctrl.sv
// STF burst sequencer: steps the STF generator address NUM_REPS x 16 times and
// registers each sample into a valid/ready stage. Define STF_WINDOW_EN to halve the first sample.
module stf_seq_ctrl #(
    parameter int unsigned NUM_REPS = 10,
    parameter int unsigned SAMPLE_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [23:0]         coeffs_in,
    output logic [3:0]          stf_addr,
    output logic [23:0]         stf_coeffs,
    input  logic [SAMPLE_W-1:0] stf_symbol,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [7:0] LastCount = 8'(NUM_REPS * 16 - 1);

    state_e              state;
    logic [7:0]          count;
    logic [SAMPLE_W-1:0] sample;
    logic                load;
    logic                accept;

`ifdef STF_WINDOW_EN
    localparam int unsigned HalfW = SAMPLE_W / 2;

    logic signed [HalfW-1:0] win_i;
    logic signed [HalfW-1:0] win_q;

    // Time-domain window: the first sample of the burst is halved per I/Q half.
    always_comb begin
        win_i  = $signed(stf_symbol[SAMPLE_W-1:HalfW]) >>> 1;
        win_q  = $signed(stf_symbol[HalfW-1:0]) >>> 1;
        sample = (count == 8'd0) ? {win_i, win_q} : stf_symbol;
    end
`else
    assign sample = stf_symbol;
`endif

    assign load   = (state == StRun) && (!out_valid || out_ready);
    assign accept = out_valid && out_ready;
    // Pulses in the acceptance cycle itself, so the block is still in DRAIN and ignores start.
    assign done   = (state == StDrain) && accept && !abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StIdle;
            count      <= 8'd0;
            stf_addr   <= 4'd0;
            stf_coeffs <= 24'd0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
        end else if (abort) begin
            state     <= StIdle;
            count     <= 8'd0;
            stf_addr  <= 4'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        stf_coeffs <= coeffs_in;
                        count      <= 8'd0;
                        stf_addr   <= 4'd0;
                        busy       <= 1'b1;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    if (load) begin
                        out_data  <= sample;
                        out_valid <= 1'b1;
                        out_last  <= (count == LastCount);
                        count     <= count + 8'd1;
                        stf_addr  <= count[3:0] + 4'd1;
                        if (count == LastCount) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_stf_seq_ctrl.sv
// Self-checking bench for stf_seq_ctrl: a burst-level model checked every cycle,
// plus directed scenarios (backpressure, abort, ignored start, NUM_REPS=1 back-to-back).
module tb_stf_seq_ctrl;

    localparam int N = 160;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, abort, out_ready;
    logic [23:0] coeffs_in;
    logic [3:0]  stf_addr;
    logic [23:0] stf_coeffs;
    logic [31:0] stf_symbol, out_data;
    logic        out_valid, out_last, busy, done;

    logic        start1, abort1, ready1;
    logic [23:0] coeffs1;
    logic [3:0]  addr1;
    logic [23:0] scoef1;
    logic [31:0] sym1, data1;
    logic        valid1, last1, busy1, done1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in generator: address 0 gives a fixed sample, others depend on the coefficients.
    function automatic logic [31:0] gen(input logic [3:0] a, input logic [23:0] c);
        return (a == 4'd0) ? 32'h8000_0002 : {c[15:0], 12'h000, a};
    endfunction

    function automatic logic [15:0] halve(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        v = (v - (v & 1)) / 2;
        return v[15:0];
    endfunction

    function automatic logic [31:0] exp_sample(input int k, input logic [23:0] c);
        logic [31:0] s;
        s = gen(4'(k % 16), c);
`ifdef STF_WINDOW_EN
        if (k == 0) s = {halve(s[31:16]), halve(s[15:0])};
`endif
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always_comb stf_symbol = gen(stf_addr, stf_coeffs);
    always_comb sym1 = gen(addr1, scoef1);

    stf_seq_ctrl u_dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .coeffs_in(coeffs_in),
        .stf_addr(stf_addr), .stf_coeffs(stf_coeffs), .stf_symbol(stf_symbol),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    stf_seq_ctrl #(.NUM_REPS(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .abort(abort1), .coeffs_in(coeffs1),
        .stf_addr(addr1), .stf_coeffs(scoef1), .stf_symbol(sym1),
        .out_data(data1), .out_valid(valid1), .out_ready(ready1),
        .out_last(last1), .busy(busy1), .done(done1)
    );

    // Burst-level model state for u_dut
    logic        chk_en = 1'b0;
    logic        m_busy = 1'b0;
    int          m_cyc = 0;
    int          m_idx = 0;
    logic [23:0] m_coeffs = 24'd0;
    logic        m_stall = 1'b0;
    logic [31:0] m_prev_data = 32'd0;
    logic        m_prev_last = 1'b0;
    logic        acc, exp_done;
    int          done_cnt = 0;
    int          vcnt = 0;
    logic [31:0] cap[$];
    logic [31:0] ref_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            acc      = out_valid && out_ready && !abort;
            exp_done = m_busy && acc && (m_idx == N - 1);
            check("busy", busy, m_busy);
            check("valid", out_valid, m_busy && (m_cyc > 0));
            check("addr", stf_addr, (m_busy && m_cyc > 0) ? 32'((m_idx + 1) % 16) : 32'd0);
            check("done", done, exp_done);
            if (!out_valid) check("last_idle", out_last, 1'b0);
            if (m_busy && out_valid) check("coeffs", stf_coeffs, m_coeffs);
            if (m_stall) begin
                check("stall_data", out_data, m_prev_data);
                check("stall_last", out_last, m_prev_last);
            end
            if (m_busy && acc) begin
                check("data", out_data, exp_sample(m_idx, m_coeffs));
                check("last", out_last, m_idx == N - 1);
                cap.push_back(out_data);
                m_idx++;
            end
            if (out_valid) vcnt++;
            if (done) done_cnt++;
            m_stall     = out_valid && !out_ready;
            m_prev_data = out_data;
            m_prev_last = out_last;
            if (abort) begin
                m_busy  = 1'b0;
                m_idx   = 0;
                m_cyc   = 0;
                m_stall = 1'b0;
            end else if (!m_busy && start) begin
                m_busy   = 1'b1;
                m_coeffs = coeffs_in;
                m_idx    = 0;
                m_cyc    = 0;
            end else if (m_busy) begin
                if (exp_done) m_busy = 1'b0;
                else m_cyc++;
            end
        end
    end

    task automatic start_burst(input logic [23:0] c);
        @(posedge clk); #1;
        start = 1'b1;
        coeffs_in = c;
        @(posedge clk); #1;
        start = 1'b0;
        coeffs_in = 24'h123456;
    endtask

    // Runs until a done pulse; optionally toggles out_ready 1,0,0,1 and re-pulses start mid-burst.
    task automatic wait_done(input int bound, input logic toggle, input logic repulse);
        int d0;
        logic [3:0] pat;
        logic fin;
        pat = 4'b1001;
        d0 = done_cnt;
        fin = 1'b0;
        for (int i = 0; i < bound && !fin; i++) begin
            @(posedge clk); #1;
            out_ready = toggle ? pat[i % 4] : 1'b1;
            if (repulse) begin
                start = (i == 50);
                coeffs_in = (i == 50) ? 24'h555555 : 24'h123456;
            end
            if (done_cnt != d0) fin = 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", fin, 1'b1);
        check("done_once", done_cnt - d0, 1);
    endtask

    task automatic burst1(output int n, output int d, output int nl);
        n = 0;
        d = 0;
        nl = 0;
        for (int i = 0; i < 60 && d == 0; i++) begin
            @(negedge clk);
            if (valid1 && ready1) begin
                n++;
                if (last1) begin
                    nl++;
                    check("r1_last_pos", n, 16);
                    check("r1_last_data", data1, 32'hAAAA_000F);
                end
            end
            if (done1) d++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, mism, n, d, nl;
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        coeffs_in = 24'h0;
        start1 = 1'b0;
        abort1 = 1'b0;
        ready1 = 1'b1;
        coeffs1 = 24'hAAAAAA;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", stf_addr, 4'd0);
        check("rst_coeffs", stf_coeffs, 24'd0);
        check("rst_data", out_data, 32'd0);
        check("rst1_busy", busy1, 1'b0);
        rstn = 1'b1;
        chk_en = 1'b1;

        // Free-running burst with an ignored start mid-run
        cap.delete();
        vcnt = 0;
        start_burst(24'hAAAAAA);
        wait_done(400, 1'b0, 1'b1);
        check("p1_vcnt", vcnt, N);
        check("p1_len", cap.size(), N);
`ifdef STF_WINDOW_EN
        check("p1_first", cap[0], 32'hC000_0001);
`else
        check("p1_first", cap[0], 32'h8000_0002);
`endif
        check("p1_second", cap[1], 32'hAAAA_0001);
        check("p1_final", cap[N-1], 32'hAAAA_000F);
        check("p1_coeffs", stf_coeffs, 24'hAAAAAA);
        @(posedge clk); #1;
        check("p1_busy_after", busy, 1'b0);
        ref_q = cap;

        // Backpressure: same stream expected
        cap.delete();
        start_burst(24'hAAAAAA);
        wait_done(1000, 1'b1, 1'b0);
        check("p2_len", cap.size(), N);
        mism = 0;
        for (int i = 0; i < N && i < cap.size(); i++) if (cap[i] !== ref_q[i]) mism++;
        check("p2_stream_eq", mism, 0);

        // Abort after 37 accepted samples
        cap.delete();
        d0 = done_cnt;
        start_burst(24'hAAAAAA);
        n = 0;
        for (int i = 0; i < 400 && n == 0; i++) begin
            @(posedge clk); #1;
            if (cap.size() == 37) n = 1;
        end
        check("p3_reach37", n, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("p3_valid", out_valid, 1'b0);
        check("p3_busy", busy, 1'b0);
        check("p3_addr", stf_addr, 4'd0);
        check("p3_last", out_last, 1'b0);
        check("p3_coeffs_kept", stf_coeffs, 24'hAAAAAA);
        repeat (5) @(posedge clk);
        #1;
        check("p3_no_done", done_cnt - d0, 0);

        // Abort and start together in IDLE: nothing starts
        start = 1'b1;
        abort = 1'b1;
        coeffs_in = 24'h555555;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("p3_abort_wins", busy, 1'b0);
        check("p3_abort_coeffs", stf_coeffs, 24'hAAAAAA);

        cap.delete();
        start_burst(24'hAAAAAA);
        wait_done(400, 1'b0, 1'b0);
        check("p3_restart_len", cap.size(), N);

        // NUM_REPS=1, back-to-back bursts
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        burst1(n, d, nl);
        check("r1a_count", n, 16);
        check("r1a_done", d, 1);
        check("r1a_lastcnt", nl, 1);
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("r1b_busy", busy1, 1'b1);
        burst1(n, d, nl);
        check("r1b_count", n, 16);
        check("r1b_done", d, 1);
        check("r1b_lastcnt", nl, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
